// File: rtl/pipeline_pkg.sv
// pipeline_pkg: fetch-stage state encoding, reset/step defaults and the IF/ID bubble encoding.
package pipeline_pkg;
    typedef enum logic [1:0] {START, REQ, HOLD, DISCARD} fetch_state_e;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;
    localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;
    localparam logic [31:0] BUBBLE_INSTR     = 32'h0;
    localparam logic        BUBBLE_VALID     = 1'b0;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register; squash beats hold, hold beats load, otherwise a bubble.
module if_id_reg
    import pipeline_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               squash,
    input  logic               hold,
    input  logic               load,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [ADDR_W-1:0]  pc4_in,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc4,
    output logic               valid
);
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc4_q, pc4_d;
    logic               valid_q, valid_d, take;

    // bubbles only clear valid; the payload keeps its stale value
    always_comb begin
        take    = !squash && !hold && load;
        instr_d = take ? instr_in : instr_q;
        pc4_d   = take ? pc4_in : pc4_q;
        valid_d = !squash && (hold ? valid_q : load);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= INSTR_W'(BUBBLE_INSTR);
            pc4_q   <= '0;
            valid_q <= BUBBLE_VALID;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign instr = instr_q;
    assign pc4   = pc4_q;
    assign valid = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, runs the imem request/ready handshake and feeds the IF/ID register.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(PC_STEP_DEFAULT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               write_PC,
    input  logic               write_IFID,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc4,
    output logic               ifid_valid
);
    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d, tgt_q, tgt_d, pc_next;
    logic [INSTR_W-1:0] buf_q, buf_d;
    logic               req_q, req_d, advance, got_rsp, fresh, load, redirect, discard_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= START;
            pc_q    <= RESET_PC;
            tgt_q   <= '0;
            buf_q   <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            buf_q   <= buf_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            START:   state_d = REQ;
            REQ:     state_d = imem_ready ? ((branch_taken || advance) ? REQ : HOLD)
                                          : (branch_taken ? DISCARD : REQ);
            HOLD:    state_d = (branch_taken || advance) ? REQ : HOLD;
            DISCARD: state_d = imem_ready ? REQ : DISCARD;
            default: state_d = START;
        endcase
    end

    // imem_addr is pc_q itself, so it cannot move until the PC is allowed to update
    always_comb begin
        advance      = write_PC && write_IFID;
        pc_next      = pc_q + PC_STEP;
        got_rsp      = (state_q == REQ) && imem_ready;
        discard_done = (state_q == DISCARD) && imem_ready;
        fresh        = !branch_taken && (got_rsp || state_q == HOLD);
        load         = fresh && advance;
        redirect     = branch_taken && (got_rsp || state_q == HOLD || discard_done);
        pc_d         = redirect ? branch_target : discard_done ? tgt_q : load ? pc_next : pc_q;
        tgt_d        = (branch_taken && (state_q == DISCARD || (state_q == REQ && !imem_ready)))
                       ? branch_target : tgt_q;
        buf_d        = got_rsp ? imem_rdata : buf_q;
        req_d        = (state_d == REQ) || (state_d == DISCARD);
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;

    if_id_reg #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_ifid (
        .clk      (clk),
        .reset    (reset),
        .squash   (branch_taken),
        .hold     (!write_IFID),
        .load     (load),
        .instr_in (state_q == HOLD ? buf_q : imem_rdata),
        .pc4_in   (pc_next),
        .instr    (ifid_instr),
        .pc4      (ifid_pc4),
        .valid    (ifid_valid)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table, reset/wrap sequences and a randomized run against a transaction model.
module tb_fetch_stage;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] bt;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evalid;
        logic [31:0] epc4;
    } vec_t;

    logic        clk = 1'b0, reset = 1'b1, w_reset = 1'b1;
    logic        write_PC = 1'b1, write_IFID = 1'b1, branch_taken = 1'b0, imem_ready = 1'b0;
    logic [31:0] branch_target = '0, imem_rdata = '0;
    logic        imem_req, ifid_valid, w_req, w_valid;
    logic [31:0] imem_addr, ifid_instr, ifid_pc4, w_addr, w_instr, w_pc4;
    int          checks = 0, errors = 0;

    logic        m_started, m_req, m_redir_v, m_v;
    logic [31:0] m_pc, m_redir, m_buf, m_instr, m_pc4;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    function automatic vec_t mk(input logic [3:0] ctl, input logic [31:0] bt, input logic ereq,
                                input logic [31:0] eaddr, input logic evalid, input logic [31:0] epc4);
        vec_t v;
        v.ctl = ctl; v.bt = bt; v.ereq = ereq; v.eaddr = eaddr; v.evalid = evalid; v.epc4 = epc4;
        return v;
    endfunction

    fetch_stage dut (
        .clk(clk), .reset(reset), .write_PC(write_PC), .write_IFID(write_IFID),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid)
    );

    fetch_stage #(.RESET_PC(WRAP_PC)) u_wrap (
        .clk(clk), .reset(w_reset), .write_PC(1'b1), .write_IFID(1'b1),
        .branch_taken(1'b0), .branch_target(32'h0),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ready(w_req), .imem_rdata(mem_word(w_addr)),
        .ifid_instr(w_instr), .ifid_pc4(w_pc4), .ifid_valid(w_valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_req = 0; m_redir_v = 0; m_v = 0;
        m_pc = 0; m_redir = 0; m_buf = 0; m_instr = 0; m_pc4 = 0;
    endtask

    // Transaction view: a fetch is outstanding, parked in a buffer, or owed a redirect.
    task automatic model_step(input logic wpc, input logic wifid, input logic br, input logic [31:0] bt,
                              input logic rdy, input logic [31:0] rd);
        logic        adv  = wpc & wifid;
        logic        got  = 0;
        logic [31:0] gi   = 0;
        logic [31:0] gpc4 = m_pc + 32'd4;
        if (!m_started) begin
            m_started = 1; m_req = 1;
        end else if (m_req) begin
            if (rdy && (m_redir_v || br)) begin m_pc = br ? bt : m_redir; m_redir_v = 0; end
            else if (rdy) begin got = 1; gi = rd; end
            else if (br) begin m_redir_v = 1; m_redir = bt; end
        end else if (br) begin
            m_req = 1; m_pc = bt;
        end else begin
            got = 1; gi = m_buf;
        end
        if (got && adv) begin m_pc = m_pc + 32'd4; m_req = 1; end
        else if (got) begin m_buf = gi; m_req = 0; end
        if (br) m_v = 0;
        else if (wifid) begin
            m_v = got && adv;
            if (got && adv) begin m_instr = gi; m_pc4 = gpc4; end
        end
    endtask

    initial begin
        vec_t vec[23];
        int   lat, r;
        vec[0]  = mk(4'b1100, 0,      1, 32'h0,   0, 0);
        vec[1]  = mk(4'b1101, 0,      1, 32'h4,   1, 32'h4);
        vec[2]  = mk(4'b1101, 0,      1, 32'h8,   1, 32'h8);
        vec[3]  = mk(4'b0001, 0,      0, 32'h8,   1, 32'h8);
        vec[4]  = mk(4'b0000, 0,      0, 32'h8,   1, 32'h8);
        vec[5]  = mk(4'b1100, 0,      1, 32'hC,   1, 32'hC);
        vec[6]  = mk(4'b1101, 0,      1, 32'h10,  1, 32'h10);
        vec[7]  = mk(4'b1110, 32'h100, 1, 32'h10, 0, 0);
        vec[8]  = mk(4'b1100, 0,      1, 32'h10,  0, 0);
        vec[9]  = mk(4'b1101, 0,      1, 32'h100, 0, 0);
        vec[10] = mk(4'b1101, 0,      1, 32'h104, 1, 32'h104);
        vec[11] = mk(4'b0001, 0,      0, 32'h104, 1, 32'h104);
        vec[12] = mk(4'b0010, 32'h200, 1, 32'h200, 0, 0);
        vec[13] = mk(4'b1101, 0,      1, 32'h204, 1, 32'h204);
        vec[14] = mk(4'b0101, 0,      0, 32'h204, 0, 0);
        vec[15] = mk(4'b1100, 0,      1, 32'h208, 1, 32'h208);
        vec[16] = mk(4'b1110, 32'h300, 1, 32'h208, 0, 0);
        vec[17] = mk(4'b1111, 32'h400, 1, 32'h400, 0, 0);
        vec[18] = mk(4'b1101, 0,      1, 32'h404, 1, 32'h404);
        vec[19] = mk(4'b1111, 32'h500, 1, 32'h500, 0, 0);
        vec[20] = mk(4'b1101, 0,      1, 32'h504, 1, 32'h504);
        vec[21] = mk(4'b1111, 32'h40, 1, 32'h40,  0, 0);
        vec[22] = mk(4'b1100, 0,      1, 32'h40,  0, 0);

        @(negedge clk);
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_valid", ifid_valid, 0);
        chk("rst_instr", ifid_instr, 0);
        chk("rst_pc4", ifid_pc4, 0);
        reset = 0;
        #1 chk("start_req", imem_req, 0);

        for (int i = 0; i < 23; i++) begin
            {write_PC, write_IFID, branch_taken, imem_ready} = vec[i].ctl;
            branch_target = vec[i].bt;
            imem_rdata    = mem_word(imem_addr);
            @(negedge clk);
            chk($sformatf("v%0d_req", i), imem_req, vec[i].ereq);
            chk($sformatf("v%0d_addr", i), imem_addr, vec[i].eaddr);
            chk($sformatf("v%0d_valid", i), ifid_valid, vec[i].evalid);
            if (vec[i].evalid) begin
                chk($sformatf("v%0d_pc4", i), ifid_pc4, vec[i].epc4);
                chk($sformatf("v%0d_instr", i), ifid_instr, mem_word(vec[i].epc4 - 32'd4));
            end
        end

        {write_PC, write_IFID, branch_taken, imem_ready} = 4'b1100;
        #2 reset = 1;
        #1;
        chk("async_req", imem_req, 0);
        chk("async_addr", imem_addr, 0);
        chk("async_valid", ifid_valid, 0);
        chk("async_instr", ifid_instr, 0);
        chk("async_pc4", ifid_pc4, 0);
        @(negedge clk) reset = 0;
        #1;
        chk("async_start_req", imem_req, 0);
        chk("async_start_addr", imem_addr, 0);
        @(negedge clk);
        chk("async_rereq", imem_req, 1);
        chk("async_readdr", imem_addr, 0);

        chk("wrap_rst_addr", w_addr, WRAP_PC);
        chk("wrap_rst_req", w_req, 0);
        w_reset = 0;
        @(negedge clk);
        chk("wrap_req", w_req, 1);
        chk("wrap_addr0", w_addr, WRAP_PC);
        @(negedge clk);
        chk("wrap_addr1", w_addr, 0);
        chk("wrap_valid", w_valid, 1);
        chk("wrap_pc4", w_pc4, 0);
        chk("wrap_instr", w_instr, mem_word(WRAP_PC));
        @(negedge clk);
        chk("wrap_addr2", w_addr, 32'h4);
        chk("wrap_pc4b", w_pc4, 32'h4);

        reset = 1;
        {write_PC, write_IFID, branch_taken, imem_ready} = 4'b1100;
        @(negedge clk) reset = 0;
        model_reset();
        lat = -1;
        for (int c = 0; c < 3000; c++) begin
            chk("rnd_req", imem_req, m_req);
            chk("rnd_addr", imem_addr, m_pc);
            chk("rnd_valid", ifid_valid, m_v);
            if (m_v) begin
                chk("rnd_instr", ifid_instr, m_instr);
                chk("rnd_pc4", ifid_pc4, m_pc4);
            end
            r             = $urandom_range(0, 9);
            write_PC      = r > 1;
            write_IFID    = r != 0;
            branch_taken  = m_started && ($urandom_range(0, 7) == 0);
            branch_target = $urandom & 32'hFFFF_FFFC;
            if (imem_req) begin
                if (lat < 0) lat = $urandom_range(0, 3);
                imem_ready = lat == 0;
                lat--;
            end else begin
                imem_ready = 0;
                lat = -1;
            end
            imem_rdata = imem_ready ? mem_word(imem_addr) : $urandom;
            model_step(write_PC, write_IFID, branch_taken, branch_target, imem_ready, imem_rdata);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
